// File: rtl/idli_fetch_m.sv
// Instruction fetch stage: runs SQI read transactions (cmd, addr, dummy, data)
// and streams each 16b word to decode as four MSB-first nibbles with its PC.
module idli_fetch_m #(
  parameter logic [15:0] RESET_PC     = 16'h0000,
  parameter int          DUMMY_CYCLES = 2,
  parameter logic [7:0]  CMD_READ     = 8'h03
) (
  input  logic        i_fch_gck,
  input  logic        i_fch_rst,
  input  logic        i_fch_en,
  input  logic        i_fch_redirect,
  input  logic [15:0] i_fch_redirect_pc,
  output logic        o_sqi_cs_n,
  output logic        o_sqi_oe,
  output logic [3:0]  o_sqi_data,
  input  logic [3:0]  i_sqi_data,
  output logic [3:0]  o_fch_enc,
  output logic        o_fch_enc_vld,
  output logic [15:0] o_fch_pc,
  output logic [1:0]  o_fch_nib
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA, ST_END
  } state_t;

  localparam logic [2:0] DUMMY_LAST = 3'(DUMMY_CYCLES - 1);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] pc_q, pc_d;
  logic        cs_n_q, cs_n_d;
  logic        oe_q, oe_d;
  logic [3:0]  sqi_data_q, sqi_data_d;
  logic [3:0]  enc_q, enc_d;
  logic        enc_vld_q, enc_vld_d;
  logic [15:0] fch_pc_q, fch_pc_d;
  logic [1:0]  nib_q, nib_d;
  logic        go_cmd;
  logic [23:0] addr_byte;

  assign addr_byte = {7'b0, pc_q, 1'b0};

  function automatic logic [3:0] addr_nib(input logic [23:0] a, input logic [2:0] idx);
    case (idx)
      3'd0:    addr_nib = a[23:20];
      3'd1:    addr_nib = a[19:16];
      3'd2:    addr_nib = a[15:12];
      3'd3:    addr_nib = a[11:8];
      3'd4:    addr_nib = a[7:4];
      3'd5:    addr_nib = a[3:0];
      default: addr_nib = 4'h0;
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_d       = pc_q;
    cs_n_d     = cs_n_q;
    oe_d       = oe_q;
    sqi_data_d = sqi_data_q;
    enc_d      = enc_q;
    enc_vld_d  = 1'b0;
    fch_pc_d   = fch_pc_q;
    nib_d      = nib_q;
    go_cmd     = 1'b0;

    case (state_q)
      ST_IDLE: go_cmd = i_fch_en;
      ST_CMD: begin
        if (cnt_q == 3'd0) begin
          sqi_data_d = CMD_READ[3:0];
          cnt_d      = 3'd1;
        end else begin
          state_d    = ST_ADDR;
          cnt_d      = 3'd0;
          sqi_data_d = addr_nib(addr_byte, 3'd0);
        end
      end
      ST_ADDR: begin
        if (cnt_q == 3'd5) begin
          state_d    = ST_DUMMY;
          cnt_d      = 3'd0;
          oe_d       = 1'b0;
          sqi_data_d = 4'h0;
        end else begin
          cnt_d      = cnt_q + 3'd1;
          sqi_data_d = addr_nib(addr_byte, cnt_q + 3'd1);
        end
      end
      ST_DUMMY: begin
        if (cnt_q == DUMMY_LAST) begin
          state_d = ST_DATA;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ST_DATA: begin
        enc_d     = i_sqi_data;
        enc_vld_d = 1'b1;
        fch_pc_d  = pc_q;
        nib_d     = cnt_q[1:0];
        // The memory's sequential address does not wrap at 16b, so a new
        // transaction is forced when the PC rolls over.
        if (cnt_q == 3'd3) begin
          pc_d  = pc_q + 16'd1;
          cnt_d = 3'd0;
          if (!i_fch_en || pc_q == 16'hFFFF) begin
            state_d = ST_END;
            cs_n_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ST_END: begin
        go_cmd  = i_fch_en;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (i_fch_redirect) begin
      pc_d       = i_fch_redirect_pc;
      enc_vld_d  = 1'b0;
      cnt_d      = 3'd0;
      oe_d       = 1'b0;
      sqi_data_d = 4'h0;
      cs_n_d     = 1'b1;
      state_d    = ST_END;
      go_cmd     = (state_q == ST_IDLE) && i_fch_en;
    end

    if (go_cmd) begin
      state_d    = ST_CMD;
      cnt_d      = 3'd0;
      cs_n_d     = 1'b0;
      oe_d       = 1'b1;
      sqi_data_d = CMD_READ[7:4];
    end
  end

  always_ff @(posedge i_fch_gck) begin
    if (i_fch_rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 3'd0;
      pc_q       <= RESET_PC;
      cs_n_q     <= 1'b1;
      oe_q       <= 1'b0;
      sqi_data_q <= 4'h0;
      enc_q      <= 4'h0;
      enc_vld_q  <= 1'b0;
      fch_pc_q   <= RESET_PC;
      nib_q      <= 2'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pc_q       <= pc_d;
      cs_n_q     <= cs_n_d;
      oe_q       <= oe_d;
      sqi_data_q <= sqi_data_d;
      enc_q      <= enc_d;
      enc_vld_q  <= enc_vld_d;
      fch_pc_q   <= fch_pc_d;
      nib_q      <= nib_d;
    end
  end

  assign o_sqi_cs_n    = cs_n_q;
  assign o_sqi_oe      = oe_q;
  assign o_sqi_data    = sqi_data_q;
  assign o_fch_enc     = enc_q;
  assign o_fch_enc_vld = enc_vld_q;
  assign o_fch_pc      = fch_pc_q;
  assign o_fch_nib     = nib_q;

endmodule

// File: tb/tb_idli_fetch_m.sv
// Bench for idli_fetch_m: SQI memory model plus an in-order word/nibble
// scoreboard, directed scenarios with literal expectations, then random traffic.
module tb_idli_fetch_m;

  localparam logic [15:0] RESET_PC = 16'h0000;
  localparam logic [7:0]  CMD_READ = 8'h03;
  localparam int          DUMMY    = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirectPc = 16'h0;
  logic        csN, oe;
  logic [3:0]  sqiOut;
  logic [3:0]  sqiIn = 4'h0;
  logic [3:0]  enc;
  logic        encVld;
  logic [15:0] fchPc;
  logic [1:0]  fchNib;

  int checks = 0;
  int fails = 0;
  int cyc = 0;

  logic        capRst = 1'b1;
  logic        capRed = 1'b0;
  logic        capEn = 1'b0;
  logic [15:0] capTgt = 16'h0;

  logic [15:0] expPc = RESET_PC;
  logic [1:0]  expNib = 2'd0;
  int          gap = 0;
  int          memK = 0;
  logic [7:0]  cmdSh = 8'h0;
  logic [23:0] addrSh = 24'h0;
  logic [23:0] addrReg = 24'h0;

  logic [3:0] startNibs [8] = '{4'h0, 4'h3, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
  logic [3:0] firstWord [4] = '{4'hA, 4'h5, 4'hC, 4'h3};
  logic [3:0] redirNibs [6] = '{4'h0, 4'h0, 4'h2, 4'h4, 4'h6, 4'h8};
  logic [3:0] wrapNibs  [6] = '{4'h0, 4'h1, 4'hF, 4'hF, 4'hF, 4'hE};

  idli_fetch_m #(
    .RESET_PC(RESET_PC), .DUMMY_CYCLES(DUMMY), .CMD_READ(CMD_READ)
  ) dut (
    .i_fch_gck(clk),
    .i_fch_rst(rst),
    .i_fch_en(en),
    .i_fch_redirect(redirect),
    .i_fch_redirect_pc(redirectPc),
    .o_sqi_cs_n(csN),
    .o_sqi_oe(oe),
    .o_sqi_data(sqiOut),
    .i_sqi_data(sqiIn),
    .o_fch_enc(enc),
    .o_fch_enc_vld(encVld),
    .o_fch_pc(fchPc),
    .o_fch_nib(fchNib)
  );

  always #5 clk = ~clk;

  // Memory contents; word addresses beyond 16 bits hold different data so a
  // transaction that runs past 0xFFFF instead of restarting gets caught.
  function automatic logic [15:0] memWord(input logic [22:0] wa);
    logic [15:0] h;
    if (wa == 23'd0) return 16'hA5C3;
    h = wa[15:0] * 16'h9E37 + 16'h7F4A;
    h = h ^ (h >> 7);
    if (wa[22:16] != 7'd0) h = ~h;
    return h;
  endfunction

  function automatic logic [3:0] nibOf(input logic [15:0] w, input int idx);
    case (idx)
      0:       return w[15:12];
      1:       return w[11:8];
      2:       return w[7:4];
      default: return w[3:0];
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic red, input logic [15:0] tgt);
    rst = r;
    en = e;
    redirect = red;
    redirectPc = tgt;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic waitFor(input logic [15:0] pc, input logic [1:0] nib);
    logic found;
    found = 1'b0;
    for (int n = 0; n < 60 && !found; n++) begin
      step();
      if (encVld === 1'b1 && fchPc === pc && fchNib === nib) found = 1'b1;
    end
    checkOutput("wait for nibble", 32'(found), 1);
  endtask

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    capRst <= rst;
    capRed <= redirect;
    capTgt <= redirectPc;
    capEn  <= en;
  end

  // Reference: words appear whole, in PC order, restarting at a redirect target
  // or RESET_PC, with data equal to memory contents at the presented PC.
  always @(negedge clk) begin
    logic ev;
    ev = 1'b0;
    if (capRst) begin
      expPc = RESET_PC;
      expNib = 2'd0;
      ev = 1'b1;
    end else if (capRed) begin
      expPc = capTgt;
      expNib = 2'd0;
      ev = 1'b1;
    end

    if (ev) begin
      checkOutput("vld after redirect/reset", 32'(encVld), 0);
    end else begin
      if (expNib != 2'd0) checkOutput("word contiguity", 32'(encVld), 1);
      if (encVld === 1'b1) begin
        checkOutput("stream pc", 32'(fchPc), 32'(expPc));
        checkOutput("stream nib", 32'(fchNib), 32'(expNib));
        checkOutput("stream data", 32'(enc), 32'(nibOf(memWord({7'b0, expPc}), int'(expNib))));
        if (expNib == 2'd3) expPc = expPc + 16'd1;
        expNib = expNib + 2'd1;
      end
    end

    if (!capEn || ev || encVld === 1'b1) gap = 0;
    else begin
      gap++;
      checkOutput("fetch progress", 32'(gap <= 16), 1);
    end

    // SQI memory: one bus cycle per clock while selected
    if (csN !== 1'b0) begin
      memK = 0;
      sqiIn = 4'($urandom_range(0, 15));
    end else begin
      if (memK < 8) checkOutput("oe while driving", 32'(oe), 1);
      else checkOutput("oe while reading", 32'(oe), 0);
      if (memK < 2) begin
        cmdSh = {cmdSh[3:0], sqiOut};
        if (memK == 1) checkOutput("read command", 32'(cmdSh), 32'(CMD_READ));
      end else if (memK < 8) begin
        addrSh = {addrSh[19:0], sqiOut};
        if (memK == 7) begin
          addrReg = addrSh;
          checkOutput("read address", 32'(addrSh), 32'({7'b0, expPc, 1'b0}));
        end
      end
      if (memK >= 8 + DUMMY)
        sqiIn = nibOf(memWord(addrReg[23:1] + 23'((memK - 8 - DUMMY) / 4)), (memK - 8 - DUMMY) % 4);
      else
        sqiIn = 4'($urandom_range(0, 15));
      memK++;
    end
  end

  initial begin
    logic e;
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0);
    repeat (3) step();
    checkOutput("reset cs_n", 32'(csN), 1);
    checkOutput("reset oe", 32'(oe), 0);
    checkOutput("reset sqi data", 32'(sqiOut), 0);
    checkOutput("reset enc", 32'(enc), 0);
    checkOutput("reset vld", 32'(encVld), 0);
    checkOutput("reset pc", 32'(fchPc), 32'(RESET_PC));
    checkOutput("reset nib", 32'(fchNib), 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
    step();
    step();
    checkOutput("idle cs_n", 32'(csN), 1);

    $display("[TB] first fetch from reset");
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);
    for (int i = 0; i < 15; i++) begin
      step();
      if (i < 8) begin
        checkOutput("start cs_n", 32'(csN), 0);
        checkOutput("start oe", 32'(oe), 1);
        checkOutput("start sqi data", 32'(sqiOut), 32'(startNibs[i]));
      end else if (i < 10) begin
        checkOutput("dummy oe", 32'(oe), 0);
      end
      checkOutput("start vld", 32'(encVld), (i >= 11) ? 32'd1 : 32'd0);
      if (i >= 11) begin
        checkOutput("first word nibble", 32'(enc), 32'(firstWord[i-11]));
        checkOutput("first word pc", 32'(fchPc), 0);
        checkOutput("first word nib", 32'(fchNib), 32'(i - 11));
      end
    end

    $display("[TB] streaming from 0x0010");
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h0010);
    step();
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);
    checkOutput("redirect vld drop", 32'(encVld), 0);
    checkOutput("redirect end cs_n", 32'(csN), 1);
    waitFor(16'h0010, 2'd0);
    for (int i = 0; i < 12; i++) begin
      if (i > 0) step();
      checkOutput("stream vld", 32'(encVld), 1);
      checkOutput("stream word pc", 32'(fchPc), 32'(16'h0010 + 16'(i / 4)));
      checkOutput("stream word nib", 32'(fchNib), 32'(i % 4));
      checkOutput("stream cs_n", 32'(csN), 0);
    end

    $display("[TB] redirect mid-word to 0x1234");
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h0010);
    step();
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);
    waitFor(16'h0010, 2'd1);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h1234);
    for (int i = 1; i <= 13; i++) begin
      step();
      if (i == 1) applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);
      checkOutput("redir cs_n", 32'(csN), (i == 1) ? 32'd1 : 32'd0);
      checkOutput("redir vld", 32'(encVld), (i == 13) ? 32'd1 : 32'd0);
      if (i >= 4 && i <= 9) checkOutput("redir address", 32'(sqiOut), 32'(redirNibs[i-4]));
      if (i == 13) begin
        checkOutput("redir first pc", 32'(fchPc), 32'h1234);
        checkOutput("redir first nib", 32'(fchNib), 0);
      end
    end

    $display("[TB] enable dropped mid-word");
    waitFor(16'h1234, 2'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
    for (int i = 1; i <= 22; i++) begin
      step();
      checkOutput("stop vld", 32'(encVld), (i <= 2) ? 32'd1 : 32'd0);
      checkOutput("stop cs_n", 32'(csN), (i >= 2) ? 32'd1 : 32'd0);
      if (i <= 2) checkOutput("stop nib", 32'(fchNib), 32'(i + 1));
    end

    $display("[TB] pc wrap at 0xFFFF");
    applyStimulus(1'b0, 1'b1, 1'b1, 16'hFFFF);
    for (int i = 1; i <= 27; i++) begin
      step();
      if (i == 1) applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);
      checkOutput("wrap cs_n", 32'(csN), (i == 15) ? 32'd1 : 32'd0);
      checkOutput("wrap vld", 32'(encVld), ((i >= 12 && i <= 15) || i == 27) ? 32'd1 : 32'd0);
      if (i == 2 || i == 17) checkOutput("wrap command", 32'(sqiOut), 3);
      if (i >= 3 && i <= 8) checkOutput("wrap address", 32'(sqiOut), 32'(wrapNibs[i-3]));
      if (i >= 18 && i <= 23) checkOutput("wrapped address", 32'(sqiOut), 0);
      if (i >= 12 && i <= 15) begin
        checkOutput("wrap pc", 32'(fchPc), 32'hFFFF);
        checkOutput("wrap nib", 32'(fchNib), 32'(i - 12));
      end
      if (i == 27) begin
        checkOutput("wrapped pc", 32'(fchPc), 0);
        checkOutput("wrapped nib", 32'(fchNib), 0);
      end
    end

    $display("[TB] reset during address phase");
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h0100);
    for (int i = 1; i <= 19; i++) begin
      step();
      if (i == 1) checkOutput("pre-reset end cs_n", 32'(csN), 1);
      if (i == 6 || i == 7) begin
        checkOutput("abort cs_n", 32'(csN), 1);
        checkOutput("abort oe", 32'(oe), 0);
        checkOutput("abort vld", 32'(encVld), 0);
      end
      if (i == 8) checkOutput("restart cs_n", 32'(csN), 0);
      if (i >= 10 && i <= 15) checkOutput("restart address", 32'(sqiOut), 0);
      if (i == 19) begin
        checkOutput("restart vld", 32'(encVld), 1);
        checkOutput("restart pc", 32'(fchPc), 32'(RESET_PC));
        checkOutput("restart nibble", 32'(enc), 32'hA);
      end
      if (i == 1) applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);
      if (i == 5) applyStimulus(1'b1, 1'b1, 1'b0, 16'h0);
      if (i == 7) applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);
    end

    $display("[TB] random traffic");
    e = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      logic r, red;
      logic [15:0] tgt;
      step();
      if (e) e = ($urandom_range(0, 49) != 0);
      else e = ($urandom_range(0, 9) == 0);
      r = ($urandom_range(0, 599) == 0);
      red = ($urandom_range(0, 39) == 0) || (redirect && $urandom_range(0, 3) == 0);
      tgt = ($urandom_range(0, 3) == 0) ? 16'hFFFF - 16'($urandom_range(0, 2)) : 16'($urandom);
      applyStimulus(r, e, red, tgt);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
    repeat (30) step();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d failures so far", fails);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
